// File: rtl/width_conv_512_64.sv
// ============================================================================
// Module   : width_conv_512_64
// Purpose  : 512-to-64 AXI-Stream serialiser, lane 0 first. Optional
//            final-word lane trim selected by macro WC_LAST_TRIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module width_conv_512_64 #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 512,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    localparam int RATIO = C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [RATIO-1:0]                  S_AXIS_TKEEP,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    localparam int DW_OUT = C_M00_AXIS_TDATA_WIDTH;
    localparam int CW     = $clog2(RATIO);
    localparam int NBW    = $clog2(RATIO + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0]   hold;
    logic                                last_flag;
    logic [NBW-1:0]                      nbeats;
    logic [NBW-1:0]                      nbeats_in;
    logic [CW-1:0]                       cnt;
    logic [CW-1:0]                       last_idx;
    logic                                is_final;
    logic                                in_hs;
    logic                                out_hs;
    logic [DW_OUT-1:0]                   lanes [RATIO];

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lanes
            assign lanes[gi] = hold[gi*DW_OUT +: DW_OUT];
        end
    endgenerate

    assign last_idx      = CW'(nbeats - NBW'(1));
    assign is_final      = (cnt == last_idx);
    assign M_AXIS_TVALID = (state == SEND);
    assign M_AXIS_TDATA  = lanes[cnt];
    assign M_AXIS_TLAST  = (state == SEND) && last_flag && is_final;
    // Ready is combinational from M_AXIS_TREADY so a new word loads on the final beat
    assign S_AXIS_TREADY = !areset && ((state == IDLE) || (is_final && M_AXIS_TREADY));
    assign in_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_hs        = M_AXIS_TVALID && M_AXIS_TREADY;

`ifdef WC_LAST_TRIM_EN
    logic keep_run;
    always_comb begin
        nbeats_in = NBW'(RATIO);
        keep_run  = 1'b1;
        if (S_AXIS_TLAST && (S_AXIS_TKEEP != '0)) begin
            nbeats_in = '0;
            for (int i = 0; i < RATIO; i++) begin
                if (keep_run && S_AXIS_TKEEP[i]) begin
                    nbeats_in = nbeats_in + NBW'(1);
                end else begin
                    keep_run = 1'b0;
                end
            end
            // Lane 0 is always sent so the packet still carries its TLAST
            if (nbeats_in == '0) begin
                nbeats_in = NBW'(1);
            end
        end
    end
`else
    logic unused_keep;
    assign unused_keep = ^S_AXIS_TKEEP;
    assign nbeats_in   = NBW'(RATIO);
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_hs && is_final && !in_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold      <= '0;
            last_flag <= 1'b0;
            nbeats    <= NBW'(RATIO);
            cnt       <= '0;
        end else if (in_hs) begin
            hold      <= S_AXIS_TDATA;
            last_flag <= S_AXIS_TLAST;
            nbeats    <= nbeats_in;
            cnt       <= '0;
        end else if (out_hs) begin
            cnt <= is_final ? '0 : cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_width_conv_512_64.sv
// Testbench for width_conv_512_64: directed and random words checked against
// a beat-queue reference model.
`default_nettype none

module tb_width_conv_512_64;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [511:0] s_tdata = '0;
    logic [7:0]   s_tkeep = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [63:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int beats_seen = 0;
    int mr_mode = 0;
    bit mr_force = 1'b1;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;
    beat_t q[$];

    always #5 aclk = ~aclk;

    width_conv_512_64 dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TKEEP  (s_tkeep),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beats a word contributes, derived from the keep/last rules
    function automatic int word_beats(input logic [7:0] k, input bit l);
        int n;
        n = 8;
`ifdef WC_LAST_TRIM_EN
        if (l && k != 8'h00) begin
            n = 0;
            while (n < 8 && k[n]) n++;
            if (n == 0) n = 1;
        end
`endif
        return n;
    endfunction

    function automatic bit pick_mr();
        case (mr_mode)
            1: return (cyc % 4 == 0) || (cyc % 4 == 3);
            2: return ($urandom_range(0, 3) != 0);
            3: return mr_force;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: drive at negedge, check settled outputs, update model, advance
    task automatic cycle(input bit sv, input logic [511:0] d, input logic [7:0] k,
                         input bit sl, output bit acc);
        bit mr;
        bit exp_rdy;
        int n;
        mr = pick_mr();
        s_tvalid = sv; s_tdata = d; s_tkeep = k; s_tlast = sl; m_tready = mr;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && mr);
        chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
        chk("s_tready", 64'(s_tready), 64'(exp_rdy));
        if (q.size() != 0) begin
            chk("m_tdata", m_tdata, q[0].d);
            chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
            if (mr) begin
                void'(q.pop_front());
                beats_seen++;
            end
        end
        acc = sv && exp_rdy;
        if (acc) begin
            n = word_beats(k, sl);
            for (int i = 0; i < n; i++) q.push_back('{d[i*64 +: 64], sl && (i == n - 1)});
        end
        @(posedge aclk);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic send_word(input logic [511:0] d, input logic [7:0] k, input bit sl);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            cycle(1'b1, d, k, sl, acc);
            guard++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, acc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        idle(1);
    endtask

    function automatic logic [511:0] seq_word(input int base);
        logic [511:0] w;
        for (int i = 0; i < 8; i++) w[i*64 +: 64] = 64'(base + i);
        return w;
    endfunction

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 8; i++) w[i*64 +: 64] = {$urandom, $urandom};
        return w;
    endfunction

    initial begin
        int base;
        bit acc;
        // Reset state
        @(negedge aclk);
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        @(negedge aclk);
        areset = 1'b0;

        // Single word, lane k = k, continuous ready
        mr_mode = 0;
        send_word(seq_word(0), 8'hFF, 1'b1);
        drain();

        // Three back-to-back words, values 0..23
        for (int w = 0; w < 3; w++) send_word(seq_word(w * 8), 8'hFF, w == 2);
        drain();

        // Output ready toggling 1,0,0,1
        mr_mode = 1;
        send_word(seq_word(100), 8'hFF, 1'b1);
        drain();

        // Full word then TLAST word with keep 0x0F
        mr_mode = 0;
        send_word(seq_word(200), 8'hFF, 1'b0);
        send_word(seq_word(208), 8'h0F, 1'b1);
        drain();

        // Reset after beat 3 of a word
        base = beats_seen;
        send_word(seq_word(300), 8'hFF, 1'b1);
        for (int i = 0; i < 10 && beats_seen < base + 3; i++) idle(1);
        areset = 1'b1;
        #1;
        chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("arst_m_tlast", 64'(m_tlast), 64'd0);
        chk("arst_s_tready", 64'(s_tready), 64'd0);
        q.delete();
        @(negedge aclk);
        areset = 1'b0;
        send_word(seq_word(400), 8'hFF, 1'b1);
        drain();

        // New word held on the final beat while output is stalled
        mr_mode = 3;
        mr_force = 1'b1;
        send_word(seq_word(500), 8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) idle(1);
        mr_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, seq_word(600), 8'hFF, 1'b1, acc);
            chk("stall_no_accept", 64'(acc), 64'd0);
        end
        mr_force = 1'b1;
        cycle(1'b1, seq_word(600), 8'hFF, 1'b1, acc);
        chk("final_beat_accept", 64'(acc), 64'd1);
        drain();

        // Random words, keep, last, gaps and backpressure
        mr_mode = 2;
        for (int w = 0; w < 40; w++) begin
            logic [7:0] k;
            k = 8'($urandom);
            if ($urandom_range(0, 1) == 1) k[0] = 1'b1;
            send_word(rand_word(), k, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/width_conv_512_64.md
# width_conv_512_64

Downstream return-path stage: accepts 512-bit AXI-Stream words from the LDPC core and serialises each into 64-bit beats for the DMA S2MM channel. It is the mirror of the 64-to-512 collector on the ingress side. Lane 0 (bits 63:0) goes out first, so a round trip through both converters preserves beat order. With the trim feature compiled in, it drops unused trailing lanes of the final word.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 512, input word width; must be an integer multiple of C_M00_AXIS_TDATA_WIDTH
- C_M00_AXIS_TDATA_WIDTH, 64, output beat width
- RATIO (localparam), C_S00/C_M00 = 8, beats per word; must be ≥2

- aclk  in  1  sole clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- S_AXIS_TDATA  in  512  input word
- S_AXIS_TKEEP  in  RATIO  one bit per 64-bit lane; used only on the TLAST word, and only with trim enabled
- S_AXIS_TVALID  in  1  word valid
- S_AXIS_TLAST  in  1  final word of packet
- S_AXIS_TREADY  out  1  converter can accept a word
- M_AXIS_TDATA  out  64  output beat
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TLAST  out  1  final beat of packet
- M_AXIS_TREADY  in  1  DMA accepts beat

## Operation
- Single 512-bit holding register, plus registered last flag, beat count `nbeats` (1..RATIO) and lane counter `cnt` (0..RATIO-1).
- States:
  - IDLE: holding register empty.
  - SEND: holding register full.
- IDLE → SEND on S_AXIS_TVALID && S_AXIS_TREADY.
  - Capture the word, TLAST and `nbeats`.
  - Set `cnt` = 0.
- In SEND:
  - M_AXIS_TDATA = hold[cnt*64 +: 64].
  - M_AXIS_TVALID = 1.
  - M_AXIS_TLAST = last_flag && (cnt == nbeats-1).
- Each output handshake (M_AXIS_TVALID && M_AXIS_TREADY) increments `cnt`.
- Final-beat handshake (cnt == nbeats-1):
  - If a new word handshakes in the same cycle: reload hold, stay in SEND, `cnt` = 0 (zero bubble).
  - Otherwise: go to IDLE.
- S_AXIS_TREADY = (state == IDLE) || (cnt == nbeats-1 && M_AXIS_TREADY). This is a combinational path from M_AXIS_TREADY.
- No data reordering, no byte swapping. Output TDATA is held stable while M_AXIS_TVALID && !M_AXIS_TREADY.
- Reset values:
  - state = IDLE, cnt = 0, nbeats = RATIO, last_flag = 0, hold = 0.
  - M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0.
  - S_AXIS_TREADY = 0 while areset is asserted, 1 after release (IDLE).
- Reset mid-packet: the partially sent word is discarded, with no TLAST emitted. The next accepted word starts at lane 0.

## Timing
- Latency: word accepted at edge N → beat 0 valid immediately after edge N (visible in cycle N+1).
- Throughput: one beat per cycle under continuous M_AXIS_TREADY. Back-to-back words give RATIO beats per word with no idle cycle.
- S_AXIS_TREADY is low for cycles 0..nbeats-2 of each word and high in the final-beat cycle only if M_AXIS_TREADY is high.
- Output backpressure stalls `cnt`. TVALID never drops while in SEND.
- TVALID is never conditioned on TREADY.
- A TVALID asserted on S with TREADY low: TDATA/TLAST/TKEEP must be held by the sender. The block samples only on handshake.

## Configuration
- WC_LAST_TRIM_EN defined:
  - On a TLAST word, `nbeats` = number of contiguous ones in S_AXIS_TKEEP starting at bit 0.
  - TKEEP = 0 is treated as all ones.
  - Non-contiguous TKEEP: `nbeats` = index of first zero. Upper lanes are dropped.
  - Non-TLAST words always use `nbeats` = RATIO, whatever TKEEP says.
- WC_LAST_TRIM_EN undefined:
  - S_AXIS_TKEEP is ignored and `nbeats` is always RATIO.
  - TLAST is emitted on lane RATIO-1 of the TLAST word.

## Test plan
- Reset release, single word 0x…07_06_05_04_03_02_01_00 (lane k = k), TLAST=1, TREADY always 1 → beats 0..7 on consecutive cycles, TLAST only on beat 7, then TVALID=0 and S_AXIS_TREADY=1.
- Three back-to-back words (lanes = 0..23), TLAST on the third → 24 contiguous beats with values 0..23, no bubble, one TLAST on value 23.
- M_AXIS_TREADY toggling 1,0,0,1 repeatedly during a word → beat values unchanged while stalled, all 8 beats delivered in order, S_AXIS_TREADY never high before the final beat.
- WC_LAST_TRIM_EN: word 2 = TLAST with TKEEP=8'h0F after a full word → 12 beats, TLAST on beat 12 (lane 3). Without the macro, the same stimulus → 16 beats, TLAST on beat 16.
- areset pulsed after beat 3 of a word → M_AXIS_TVALID=0 asynchronously. After release, a new word is sent from lane 0, and no stale beats or TLAST appear.
- S_AXIS_TVALID presented while SEND with M_AXIS_TREADY=0 on the final beat → no acceptance until M_AXIS_TREADY=1, then the word is accepted in the same cycle as final beat.
